// File: rtl/store_buffer_if.sv
// Store buffer port bundle: D-cache enqueue side, drain side, load-forward lookup and occupancy status.
interface store_buffer_if;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_byte_en;
  logic        enq_ready;
  logic        drain_valid;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_byte_en;
  logic        drain_ready;
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic        fwd_partial;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, fwd_addr,
    input  enq_ready, drain_valid, drain_addr, drain_data, drain_byte_en,
           fwd_hit, fwd_partial, fwd_data, count, empty, full
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_byte_en, drain_ready, fwd_addr,
    output enq_ready, drain_valid, drain_addr, drain_data, drain_byte_en,
           fwd_hit, fwd_partial, fwd_data, count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// 4-entry in-order store buffer with combinational store-to-load forwarding.
// Entries retire strictly in enqueue order; no bypass from enqueue to drain.
module store_buffer (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave sb
);
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic   [DEPTH-1:0] vld_q, vld_d;
  logic   [1:0]       wr_ptr_q, wr_ptr_d;
  logic   [1:0]       rd_ptr_q, rd_ptr_d;
  logic   [2:0]       count_q, count_d;

  logic   full, empty, enq_fire, drain_fire;
  entry_t head;
  logic   [3:0]  fwd_cov;
  logic   [31:0] fwd_word;
  logic   [1:0]  idx;

  assign full       = (count_q == 3'd4);
  assign empty      = (count_q == 3'd0);
  // Full blocks enqueue even when a drain frees a slot this cycle.
  assign enq_fire   = sb.enq_valid && !full && (sb.enq_byte_en != 4'b0000);
  assign drain_fire = !empty && sb.drain_ready;

  always_comb begin
    ent_d    = ent_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_fire) begin
      ent_d[wr_ptr_q] = '{addr: sb.enq_addr, data: sb.enq_data, be: sb.enq_byte_en};
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (drain_fire) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, enq_fire} - {2'b00, drain_fire};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Walk oldest to youngest so younger matching bytes overwrite older ones.
  // Only registered entries are visible, so a same-cycle enqueue never forwards.
  always_comb begin
    fwd_cov  = '0;
    fwd_word = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + 2'(i);
      if (vld_q[idx] && (ent_q[idx].addr[31:2] == sb.fwd_addr[31:2])) begin
        fwd_cov = fwd_cov | ent_q[idx].be;
        for (int b = 0; b < 4; b++)
          if (ent_q[idx].be[b]) fwd_word[8*b +: 8] = ent_q[idx].data[8*b +: 8];
      end
    end
  end

  assign head = empty ? '0 : ent_q[rd_ptr_q];

  assign sb.enq_ready     = !full;
  assign sb.drain_valid   = !empty;
  assign sb.drain_addr    = head.addr;
  assign sb.drain_data    = head.data;
  assign sb.drain_byte_en = head.be;
  assign sb.fwd_hit       = (fwd_cov == 4'b1111);
  assign sb.fwd_partial   = (fwd_cov != 4'b0000) && (fwd_cov != 4'b1111);
  assign sb.fwd_data      = fwd_word;
  assign sb.count         = count_q;
  assign sb.empty         = empty;
  assign sb.full          = full;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: ordering, full/empty edges, forwarding merge and async reset.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  store_buffer_if sbi();
  store_buffer dut (.clk(clk), .reset(reset), .sb(sbi));

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sbi.enq_valid   = 1'b0;
    sbi.enq_addr    = '0;
    sbi.enq_data    = '0;
    sbi.enq_byte_en = '0;
    sbi.drain_ready = 1'b0;
    sbi.fwd_addr    = '0;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sbi.enq_valid = 1'b1; sbi.enq_addr = a; sbi.enq_data = d; sbi.enq_byte_en = be;
    step();
    sbi.enq_valid = 1'b0; sbi.enq_byte_en = '0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    checks++; if (sbi.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", sbi.count); end
    checks++; if ({sbi.empty, sbi.full, sbi.enq_ready, sbi.drain_valid} !== 4'b1010) begin errors++; $display("FAIL reset_flags: got %b exp 1010", {sbi.empty, sbi.full, sbi.enq_ready, sbi.drain_valid}); end
    checks++; if ({sbi.drain_addr, sbi.drain_data, sbi.drain_byte_en, sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data} !== '0) begin errors++; $display("FAIL reset_outputs: drain %h/%h/%b fwd %b%b %h exp zeros", sbi.drain_addr, sbi.drain_data, sbi.drain_byte_en, sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    sbi.fwd_addr = 32'h100;
    sbi.enq_valid = 1'b1; sbi.enq_addr = 32'h100; sbi.enq_data = 32'h11223344; sbi.enq_byte_en = 4'b1111;
    #1;
    checks++; if (sbi.drain_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got drain_valid %b exp 0", sbi.drain_valid); end
    checks++; if (sbi.fwd_hit !== 1'b0) begin errors++; $display("FAIL enq_no_fwd: got fwd_hit %b exp 0", sbi.fwd_hit); end
    step();
    sbi.enq_valid = 1'b0; sbi.enq_byte_en = '0;
    #1;
    checks++; if ({sbi.drain_valid, sbi.drain_addr, sbi.drain_data, sbi.drain_byte_en} !== {1'b1, 32'h100, 32'h11223344, 4'b1111}) begin errors++; $display("FAIL basic_head: got %b %h %h %b exp 1 100 11223344 1111", sbi.drain_valid, sbi.drain_addr, sbi.drain_data, sbi.drain_byte_en); end
    checks++; if (sbi.count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d exp 1", sbi.count); end
    sbi.drain_ready = 1'b1;
    #1;
    checks++; if ({sbi.fwd_hit, sbi.fwd_data} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL drain_fwd: got %b %h exp 1 11223344", sbi.fwd_hit, sbi.fwd_data); end
    step();
    sbi.drain_ready = 1'b0;
    #1;
    checks++; if ({sbi.empty, sbi.drain_valid, sbi.drain_addr} !== {2'b10, 32'h0}) begin errors++; $display("FAIL basic_empty: got %b %b %h exp 1 0 0", sbi.empty, sbi.drain_valid, sbi.drain_addr); end
    // Zero byte enables are not a store.
    sbi.enq_valid = 1'b1; sbi.enq_addr = 32'h500; sbi.enq_byte_en = 4'b0000;
    step();
    sbi.enq_valid = 1'b0;
    #1;
    checks++; if ({sbi.count, sbi.empty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL zero_be: got count %0d empty %b exp 0 1", sbi.count, sbi.empty); end
    sbi.fwd_addr = '0;
  endtask

  task automatic test_full();
    logic [31:0] exp_q [$];
    enq(32'h10, 32'hD0, 4'b1111);
    enq(32'h14, 32'hD1, 4'b1111);
    enq(32'h18, 32'hD2, 4'b1111);
    enq(32'h1C, 32'hD3, 4'b1111);
    checks++; if ({sbi.full, sbi.enq_ready, sbi.count} !== {2'b10, 3'd4}) begin errors++; $display("FAIL full_flags: got %b %b %0d exp 1 0 4", sbi.full, sbi.enq_ready, sbi.count); end
    enq(32'h20, 32'hE0, 4'b1111);
    checks++; if (sbi.count !== 3'd4) begin errors++; $display("FAIL full_ignore: got %0d exp 4", sbi.count); end
    // Full with both sides active: only the drain fires.
    sbi.enq_valid = 1'b1; sbi.enq_addr = 32'h20; sbi.enq_data = 32'hE0; sbi.enq_byte_en = 4'b1111;
    sbi.drain_ready = 1'b1;
    step();
    sbi.enq_valid = 1'b0; sbi.drain_ready = 1'b0;
    #1;
    checks++; if ({sbi.count, sbi.drain_data} !== {3'd3, 32'hD1}) begin errors++; $display("FAIL full_both: got count %0d head %h exp 3 D1", sbi.count, sbi.drain_data); end
    sbi.drain_ready = 1'b1;
    step();
    sbi.drain_ready = 1'b0;
    sbi.enq_valid = 1'b1; sbi.enq_addr = 32'h24; sbi.enq_data = 32'hE1; sbi.enq_byte_en = 4'b1111;
    sbi.drain_ready = 1'b1;
    step();
    sbi.enq_valid = 1'b0; sbi.drain_ready = 1'b0;
    #1;
    checks++; if (sbi.count !== 3'd2) begin errors++; $display("FAIL both_count: got %0d exp 2", sbi.count); end
    exp_q = '{32'hD3, 32'hE1};
    foreach (exp_q[i]) begin
      checks++; if (sbi.drain_data !== exp_q[i]) begin errors++; $display("FAIL drain_order_%0d: got %h exp %h", i, sbi.drain_data, exp_q[i]); end
      sbi.drain_ready = 1'b1;
      step();
      sbi.drain_ready = 1'b0;
      #1;
    end
    checks++; if ({sbi.empty, sbi.count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL full_drained: got %b %0d exp 1 0", sbi.empty, sbi.count); end
  endtask

  task automatic test_fwd_merge();
    enq(32'h200, 32'hAABBCCDD, 4'b1111);
    enq(32'h200, 32'h00000011, 4'b0001);
    sbi.fwd_addr = 32'h202;
    #1;
    checks++; if ({sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data} !== {2'b10, 32'hAABBCC11}) begin errors++; $display("FAIL fwd_merge: got %b%b %h exp 10 AABBCC11", sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data); end
    sbi.drain_ready = 1'b1;
    step(); step();
    sbi.drain_ready = 1'b0;
    sbi.fwd_addr = '0;
    #1;
  endtask

  task automatic test_fwd_partial();
    enq(32'h300, 32'h0000EE00, 4'b0010);
    sbi.fwd_addr = 32'h300;
    #1;
    checks++; if ({sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data} !== {2'b01, 32'h0000EE00}) begin errors++; $display("FAIL fwd_partial: got %b%b %h exp 01 0000EE00", sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data); end
    sbi.fwd_addr = 32'h304;
    #1;
    checks++; if ({sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data} !== {2'b00, 32'h0}) begin errors++; $display("FAIL fwd_miss: got %b%b %h exp 00 0", sbi.fwd_hit, sbi.fwd_partial, sbi.fwd_data); end
    sbi.fwd_addr = '0;
  endtask

  task automatic test_reset_mid();
    enq(32'h400, 32'h44444444, 4'b1111);
    enq(32'h404, 32'h55555555, 4'b1111);
    checks++; if (sbi.count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d exp 3", sbi.count); end
    sbi.fwd_addr = 32'h400;
    sbi.drain_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({sbi.count, sbi.drain_valid, sbi.fwd_hit, sbi.fwd_partial} !== {3'd0, 3'b000}) begin errors++; $display("FAIL mid_reset: got count %0d dv %b hit %b part %b exp 0 0 0 0", sbi.count, sbi.drain_valid, sbi.fwd_hit, sbi.fwd_partial); end
    step();
    idle();
    reset = 1'b0;
    step();
    checks++; if ({sbi.count, sbi.empty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL post_reset: got count %0d empty %b exp 0 1", sbi.count, sbi.empty); end
    enq(32'h100, 32'h11223344, 4'b1111);
    checks++; if ({sbi.drain_valid, sbi.drain_addr, sbi.count} !== {1'b1, 32'h100, 3'd1}) begin errors++; $display("FAIL post_reset_enq: got %b %h %0d exp 1 100 1", sbi.drain_valid, sbi.drain_addr, sbi.count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_full();
    test_fwd_merge();
    test_fwd_partial();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
